regfile_bypass_scoreboard: RTL and testbench
============================================

Name: regfile_bypass_scoreboard

Overview:
- 32-entry x 32-bit register file; the responder to the register-file control logic, which drives its read/write ports.
- Provides two combinational read ports and one clocked write port.
- r0 is hardwired to zero; optional same-cycle write-through bypass.
- Holds a pending-write scoreboard for the long-latency mult/div unit, so decode can stall on RAW hazards against an in-flight mult/div destination.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, register address width; register count = 2**ADDR_W

Ports:
clock  input  1  system clock, rising edge
ctrl_reset  input  1  asynchronous, active-high reset
ctrl_writeEnable  input  1  write strobe from regfile control (wE)
ctrl_writeReg  input  ADDR_W  write address (writeD)
data_writeReg  input  DATA_W  write data
ctrl_readRegA  input  ADDR_W  read address A (readA)
ctrl_readRegB  input  ADDR_W  read address B (readB)
data_readRegA  output  DATA_W  read data A
data_readRegB  output  DATA_W  read data B
md_issue  input  1  mult/div op accepted into unit this cycle
md_issue_reg  input  ADDR_W  destination register of issued op
md_wb  input  1  current write is a mult/div result (multOrDivReady)
stall_A  output  1  read A targets a pending mult/div destination
stall_B  output  1  read B targets a pending mult/div destination
md_pending  output  1  a mult/div result is outstanding
md_issue_err  output  1  registered one-cycle pulse: issue while already pending

Behaviour:
- Reset is asynchronous, active-high, on ctrl_reset. While asserted:
  - all registers = 0
  - pending bits = 0, md_issue_err = 0
  - data_readRegA/B = 0, stall_A/B = 0, md_pending = 0
- Write:
  - On rising clock edge, when ctrl_writeEnable=1 and ctrl_writeReg!=0: reg[ctrl_writeReg] <= data_writeReg.
  - Writes to r0 are dropped.
  - Write latency is 1 cycle.
- Read:
  - Combinational.
  - data_readRegX = 0 when the address is 0; otherwise reg[addr] (subject to bypass, see Optional Feature).
- Scoreboard: one pending bit per register, with at most one mult/div op in flight.
  - Set: on a clock edge with md_issue=1, md_issue_reg!=0 and md_pending=0, pending[md_issue_reg] <= 1.
  - Issue to r0: ignored, nothing is set.
  - Clear: on a clock edge with ctrl_writeEnable=1 and md_wb=1, pending[ctrl_writeReg] <= 0.
  - Simultaneous set and clear to the same register in one cycle (retire plus back-to-back issue): set wins, bit stays 1.
  - Issue is accepted in the retire cycle: md_pending is evaluated after the clear, so a same-cycle retire frees the slot.
  - Issue while md_pending=1 and no same-cycle retire: issue is ignored; md_issue_err = 1 for the following cycle only.
  - A normal (non-md_wb) write to a pending register does not clear its pending bit.
- Stall outputs:
  - stall_X = pending[ctrl_readRegX] (combinational on address, registered bits).
  - stall_X is 0 for address 0.
  - stall_X = 0 in the cycle the matching md_wb write occurs, and only when bypass is enabled; otherwise it drops the next cycle.
- md_pending = OR of all pending bits.

Optional Feature:
- Macro: REGFILE_WRITE_BYPASS_EN
- Defined:
  - If ctrl_writeEnable=1, ctrl_writeReg!=0 and ctrl_writeReg==ctrl_readRegX, then data_readRegX = data_writeReg in the same cycle.
  - stall_X is also masked in that case when md_wb=1.
- Undefined:
  - Reads return the stored value; the new value is visible the cycle after the write.
  - Stall masking is absent.

Test Plan:
- Reset: write r5=0xDEADBEEF, then assert ctrl_reset mid-cycle (no clock edge) -> data_readRegA (addr 5) = 0 immediately; stall_A = 0; md_pending = 0.
- r0: write r0=0xFFFFFFFF -> reading r0 on A and B = 0; write r31=0x12345678 -> read r31 next cycle = 0x12345678.
- Bypass: same-cycle write r7=0xA5A5A5A5 with readA=7 -> with macro defined, data_readRegA=0xA5A5A5A5 that cycle; without it, old value 0 that cycle and 0xA5A5A5A5 the next cycle.
- Scoreboard: issue md to r9 -> next cycle stall_B=1 for readB=9, md_pending=1. Normal write to r9 -> stall persists. md_wb write r9=0x64 -> pending clears; read r9=0x64.
- Back-to-back: md_wb retire r9 while issuing to r9 -> pending[9] stays 1. Retire r9 while issuing to r4 -> pending[9]=0, pending[4]=1.
- Error: issue to r3 while r9 pending, no retire -> md_issue_err=1 for exactly one cycle; pending[3]=0. Issue to r0 -> no pending set.

Source files
------------

// File: rtl/regfile_bypass_scoreboard.sv
// 32x32 register file with two combinational read ports, one write port, r0 tied to zero,
// and a pending-write scoreboard for one in-flight mult/div op. Define REGFILE_WRITE_BYPASS_EN for write-through.
module regfile_bypass_scoreboard #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic              clock,
   input  logic              ctrl_reset,
   input  logic              ctrl_writeEnable,
   input  logic [ADDR_W-1:0] ctrl_writeReg,
   input  logic [DATA_W-1:0] data_writeReg,
   input  logic [ADDR_W-1:0] ctrl_readRegA,
   input  logic [ADDR_W-1:0] ctrl_readRegB,
   output logic [DATA_W-1:0] data_readRegA,
   output logic [DATA_W-1:0] data_readRegB,
   input  logic              md_issue,
   input  logic [ADDR_W-1:0] md_issue_reg,
   input  logic              md_wb,
   output logic              stall_A,
   output logic              stall_B,
   output logic              md_pending,
   output logic              md_issue_err
);

   localparam int NREG = 2 ** ADDR_W;

   logic [DATA_W-1:0] regs_q [NREG];
   logic [NREG-1:0]   pending_q, pending_d;
   logic              issue_err_q, issue_err_d;

   logic              wr_valid;
   logic              md_retire;
   logic [NREG-1:0]   clr_mask;
   logic [NREG-1:0]   set_mask;
   logic              slot_free;

   assign wr_valid  = ctrl_writeEnable && (ctrl_writeReg != '0);
   assign md_retire = ctrl_writeEnable && md_wb;

   always_ff @(posedge clock or posedge ctrl_reset) begin
      if (ctrl_reset) begin
         for (int i = 0; i < NREG; i++) begin
            regs_q[i] <= '0;
         end
      end else if (wr_valid) begin
         regs_q[ctrl_writeReg] <= data_writeReg;
      end
   end

   // Slot occupancy is judged after this cycle's retire, so a retire and a new issue can overlap.
   always_comb begin
      clr_mask    = '0;
      set_mask    = '0;
      if (md_retire) begin
         clr_mask = NREG'(1) << ctrl_writeReg;
      end
      slot_free   = ~|(pending_q & ~clr_mask);
      if (md_issue && (md_issue_reg != '0) && slot_free) begin
         set_mask = NREG'(1) << md_issue_reg;
      end
      pending_d   = (pending_q & ~clr_mask) | set_mask;
      issue_err_d = md_issue && !slot_free;
   end

   always_ff @(posedge clock or posedge ctrl_reset) begin
      if (ctrl_reset) begin
         pending_q   <= '0;
         issue_err_q <= 1'b0;
      end else begin
         pending_q   <= pending_d;
         issue_err_q <= issue_err_d;
      end
   end

   logic [DATA_W-1:0] rd_a, rd_b;
   logic              st_a, st_b;

   always_comb begin
      rd_a = (ctrl_readRegA == '0) ? '0 : regs_q[ctrl_readRegA];
      rd_b = (ctrl_readRegB == '0) ? '0 : regs_q[ctrl_readRegB];
      st_a = (ctrl_readRegA != '0) && pending_q[ctrl_readRegA];
      st_b = (ctrl_readRegB != '0) && pending_q[ctrl_readRegB];
`ifdef REGFILE_WRITE_BYPASS_EN
      if (wr_valid && (ctrl_writeReg == ctrl_readRegA)) begin
         rd_a = data_writeReg;
         if (md_wb) st_a = 1'b0;
      end
      if (wr_valid && (ctrl_writeReg == ctrl_readRegB)) begin
         rd_b = data_writeReg;
         if (md_wb) st_b = 1'b0;
      end
`endif
   end

   // Gate with reset so a write presented during reset cannot leak through the bypass.
   assign data_readRegA = ctrl_reset ? '0 : rd_a;
   assign data_readRegB = ctrl_reset ? '0 : rd_b;
   assign stall_A       = !ctrl_reset && st_a;
   assign stall_B       = !ctrl_reset && st_b;
   assign md_pending    = |pending_q;
   assign md_issue_err  = issue_err_q;

endmodule

// File: tb/tb_regfile_bypass_scoreboard.sv
// Directed vector bench for regfile_bypass_scoreboard; expectations follow the build's bypass setting.
module tb_regfile_bypass_scoreboard;

`ifdef REGFILE_WRITE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic        clock = 1'b0;
   logic        ctrl_reset;
   logic        ctrl_writeEnable;
   logic [4:0]  ctrl_writeReg;
   logic [31:0] data_writeReg;
   logic [4:0]  ctrl_readRegA, ctrl_readRegB;
   logic [31:0] data_readRegA, data_readRegB;
   logic        md_issue;
   logic [4:0]  md_issue_reg;
   logic        md_wb;
   logic        stall_A, stall_B, md_pending, md_issue_err;

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clock = ~clock;

   regfile_bypass_scoreboard dut (
      .clock           (clock),
      .ctrl_reset      (ctrl_reset),
      .ctrl_writeEnable(ctrl_writeEnable),
      .ctrl_writeReg   (ctrl_writeReg),
      .data_writeReg   (data_writeReg),
      .ctrl_readRegA   (ctrl_readRegA),
      .ctrl_readRegB   (ctrl_readRegB),
      .data_readRegA   (data_readRegA),
      .data_readRegB   (data_readRegB),
      .md_issue        (md_issue),
      .md_issue_reg    (md_issue_reg),
      .md_wb           (md_wb),
      .stall_A         (stall_A),
      .stall_B         (stall_B),
      .md_pending      (md_pending),
      .md_issue_err    (md_issue_err)
   );

   typedef struct {
      logic        we;
      logic [4:0]  wreg;
      logic [31:0] wdata;
      logic [4:0]  ra, rb;
      logic        iss;
      logic [4:0]  ireg;
      logic        wb;
      logic [31:0] ea, eb;
      logic        esa, esb, epend, eerr;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic we, logic [4:0] wreg, logic [31:0] wdata,
                               logic [4:0] ra, logic [4:0] rb,
                               logic iss, logic [4:0] ireg, logic wb,
                               logic [31:0] ea, logic [31:0] eb,
                               logic esa, logic esb, logic epend, logic eerr);
      vec_t v;
      v.we = we; v.wreg = wreg; v.wdata = wdata; v.ra = ra; v.rb = rb;
      v.iss = iss; v.ireg = ireg; v.wb = wb; v.ea = ea; v.eb = eb;
      v.esa = esa; v.esb = esb; v.epend = epend; v.eerr = eerr;
      return v;
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(logic we, logic [4:0] wreg, logic [31:0] wdata, logic [4:0] ra,
                        logic [4:0] rb, logic iss, logic [4:0] ireg, logic wb);
      ctrl_writeEnable = we; ctrl_writeReg = wreg; data_writeReg = wdata;
      ctrl_readRegA = ra; ctrl_readRegB = rb;
      md_issue = iss; md_issue_reg = ireg; md_wb = wb;
   endtask

   task automatic check_outs(string tag, vec_t v);
      chk({tag, " rdA"},  data_readRegA, v.ea);
      chk({tag, " rdB"},  data_readRegB, v.eb);
      chk({tag, " stA"},  32'(stall_A), 32'(v.esa));
      chk({tag, " stB"},  32'(stall_B), 32'(v.esb));
      chk({tag, " pend"}, 32'(md_pending), 32'(v.epend));
      chk({tag, " err"},  32'(md_issue_err), 32'(v.eerr));
   endtask

   initial begin
      ctrl_reset = 1'b1;
      drive(0, 0, 0, 0, 0, 0, 0, 0);

      //          we wreg wdata         ra  rb  iss ireg wb  expA                        expB          sA         sB pend err
      vecs.push_back(mk(0, 0,  32'h0,        0,  0,  0, 0, 0, 32'h0,                      32'h0,        0,         0, 0, 0));
      vecs.push_back(mk(1, 0,  32'hFFFFFFFF, 0,  0,  0, 0, 0, 32'h0,                      32'h0,        0,         0, 0, 0));
      vecs.push_back(mk(0, 0,  32'h0,        0,  0,  0, 0, 0, 32'h0,                      32'h0,        0,         0, 0, 0));
      vecs.push_back(mk(1, 31, 32'h12345678, 31, 0,  0, 0, 0, BYP ? 32'h12345678 : 32'h0, 32'h0,        0,         0, 0, 0));
      vecs.push_back(mk(0, 0,  32'h0,        31, 0,  0, 0, 0, 32'h12345678,               32'h0,        0,         0, 0, 0));
      vecs.push_back(mk(1, 7,  32'hA5A5A5A5, 7,  31, 0, 0, 0, BYP ? 32'hA5A5A5A5 : 32'h0, 32'h12345678, 0,         0, 0, 0));
      vecs.push_back(mk(0, 0,  32'h0,        7,  7,  0, 0, 0, 32'hA5A5A5A5,               32'hA5A5A5A5, 0,         0, 0, 0));
      vecs.push_back(mk(0, 0,  32'h0,        9,  9,  1, 9, 0, 32'h0,                      32'h0,        0,         0, 0, 0));
      vecs.push_back(mk(0, 0,  32'h0,        0,  9,  0, 0, 0, 32'h0,                      32'h0,        0,         1, 1, 0));
      vecs.push_back(mk(1, 9,  32'h11,       9,  9,  0, 0, 0, BYP ? 32'h11 : 32'h0,       32'h0,        1,         1, 1, 0));
      vecs.push_back(mk(0, 0,  32'h0,        9,  9,  0, 0, 0, 32'h11,                     32'h11,       1,         1, 1, 0));
      vecs.push_back(mk(1, 9,  32'h64,       9,  9,  0, 0, 1, BYP ? 32'h64 : 32'h11,      BYP ? 32'h64 : 32'h11, !BYP, !BYP, 1, 0));
      vecs.push_back(mk(0, 0,  32'h0,        9,  9,  0, 0, 0, 32'h64,                     32'h64,       0,         0, 0, 0));
      vecs.push_back(mk(0, 0,  32'h0,        9,  0,  1, 9, 0, 32'h64,                     32'h0,        0,         0, 0, 0));
      vecs.push_back(mk(1, 9,  32'h100,      9,  0,  1, 9, 1, BYP ? 32'h100 : 32'h64,     32'h0,        !BYP,      0, 1, 0));
      vecs.push_back(mk(0, 0,  32'h0,        9,  0,  0, 0, 0, 32'h100,                    32'h0,        1,         0, 1, 0));
      vecs.push_back(mk(1, 9,  32'h200,      9,  4,  1, 4, 1, BYP ? 32'h200 : 32'h100,    32'h0,        !BYP,      0, 1, 0));
      vecs.push_back(mk(0, 0,  32'h0,        9,  4,  0, 0, 0, 32'h200,                    32'h0,        0,         1, 1, 0));
      vecs.push_back(mk(0, 0,  32'h0,        3,  4,  1, 3, 0, 32'h0,                      32'h0,        0,         1, 1, 0));
      vecs.push_back(mk(0, 0,  32'h0,        3,  4,  0, 0, 0, 32'h0,                      32'h0,        0,         1, 1, 1));
      vecs.push_back(mk(0, 0,  32'h0,        3,  4,  0, 0, 0, 32'h0,                      32'h0,        0,         1, 1, 0));
      vecs.push_back(mk(1, 4,  32'h5,        4,  0,  0, 0, 1, BYP ? 32'h5 : 32'h0,        32'h0,        !BYP,      0, 1, 0));
      vecs.push_back(mk(0, 0,  32'h0,        4,  0,  0, 0, 0, 32'h5,                      32'h0,        0,         0, 0, 0));
      vecs.push_back(mk(0, 0,  32'h0,        0,  0,  1, 0, 0, 32'h0,                      32'h0,        0,         0, 0, 0));
      vecs.push_back(mk(0, 0,  32'h0,        0,  0,  0, 0, 0, 32'h0,                      32'h0,        0,         0, 0, 0));

      repeat (2) @(posedge clock);
      @(negedge clock);
      ctrl_reset = 1'b0;

      foreach (vecs[i]) begin
         @(negedge clock);
         drive(vecs[i].we, vecs[i].wreg, vecs[i].wdata, vecs[i].ra, vecs[i].rb,
               vecs[i].iss, vecs[i].ireg, vecs[i].wb);
         #1;
         check_outs($sformatf("v%0d", i), vecs[i]);
      end

      // Asynchronous reset mid-cycle with a register written, a destination pending and an error pulse live.
      @(negedge clock); drive(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0);
      @(negedge clock); drive(0, 0, 0, 0, 0, 1, 5, 0);
      @(negedge clock); drive(0, 0, 0, 0, 0, 1, 6, 0);
      @(negedge clock); drive(0, 0, 0, 5, 6, 0, 0, 0);
      #1;
      check_outs("pre_rst", mk(0, 0, 0, 5, 6, 0, 0, 0, 32'hDEADBEEF, 32'h0, 1, 0, 1, 1));
      ctrl_reset = 1'b1;
      #1;
      check_outs("in_rst", mk(0, 0, 0, 5, 6, 0, 0, 0, 32'h0, 32'h0, 0, 0, 0, 0));
      @(negedge clock);
      ctrl_reset = 1'b0;
      drive(0, 0, 0, 5, 31, 0, 0, 0);
      #1;
      check_outs("post_rst", mk(0, 0, 0, 5, 31, 0, 0, 0, 32'h0, 32'h0, 0, 0, 0, 0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
